// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between the team's APB master and the register-bank completer.
// The master modport drives the request side; the slave modport answers it.
interface apb_slave_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer with an ID register, a run-time wait-state register and a bank
// of general R/W registers; answers bad address, misalignment and ID writes with pslverr.
module apb_slave_regs #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input logic              pclk,
  input logic              prst,
  apb_slave_regs_if.slave  bus
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t        r_state;
  logic [3:0]    r_wcnt;
  logic          r_write;
  logic [IW-1:0] r_index;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [31:0]   r_prdata;
  logic [3:0]    r_waitcfg;
  logic [31:0]   r_gpr [NUM_REGS-2];

  state_t      w_state_next;
  logic        w_setup;
  logic        w_commit;
  logic [31:0] w_offset;
  logic [31:0] w_index_full;
  logic        w_err;
  logic [31:0] w_rdata;

  // Address decode happens on the live bus during the setup phase.
  assign w_offset     = bus.paddr - BASE_ADDR;
  assign w_index_full = w_offset >> 2;
  assign w_err        = (bus.paddr[1:0] != 2'b00)
                      | (bus.paddr < BASE_ADDR)
                      | (w_index_full >= 32'(NUM_REGS))
                      | (bus.pwrite && (w_index_full == 32'd0));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_rdata = 32'd0;
    if (w_index_full == 32'd0) begin
      w_rdata = ID_VALUE;
    end else if (w_index_full == 32'd1) begin
      w_rdata = {28'd0, r_waitcfg};
    end else begin
      for (int i = 2; i < int'(NUM_REGS); i++) begin
        if (w_index_full == 32'(i)) w_rdata = r_gpr[i-2];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_setup      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An access strobe without a preceding setup phase is ignored.
        if (bus.psel && !bus.penable) begin
          w_setup      = 1'b1;
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          w_state_next = ST_IDLE;
        end else if ((r_wcnt == 4'd0) && bus.penable) begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= 4'd0;
      r_write   <= 1'b0;
      r_index   <= '0;
      r_wdata   <= 32'd0;
      r_err     <= 1'b0;
      r_prdata  <= 32'd0;
      r_waitcfg <= 4'(WAIT_STATES);
      // NOTE: the register bank is architecturally visible, so every entry is reset (it is flops, not RAM).
      for (int i = 0; i < int'(NUM_REGS) - 2; i++) r_gpr[i] <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_setup) begin
        r_write  <= bus.pwrite;
        r_index  <= w_index_full[IW-1:0];
        r_wdata  <= bus.pwdata;
        r_err    <= w_err;
        r_wcnt   <= r_waitcfg;
        r_prdata <= (bus.pwrite || w_err) ? 32'd0 : w_rdata;
      end else if ((r_state == ST_ACCESS) && bus.psel && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      // Index 0 can never reach here on a write: it is flagged as an error at setup.
      if (w_commit && r_write && !r_err) begin
        if (r_index == IW'(1)) r_waitcfg <= r_wdata[3:0];
        for (int i = 2; i < int'(NUM_REGS); i++) begin
          if (r_index == IW'(i)) r_gpr[i-2] <= r_wdata;
        end
      end
    end
  end

  assign bus.pready  = (r_state == ST_ACCESS) && (r_wcnt == 4'd0);
  assign bus.pslverr = bus.pready && r_err;
  assign bus.prdata  = r_prdata;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: a table of back-to-back APB transfers with
// hand-computed results, plus sequences for penable-only, abort and mid-transfer reset.
module tb_apb_slave_regs;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  logic pclk;
  logic prst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [16];

  apb_slave_regs_if bus ();

  apb_slave_regs #(
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_STATES(0),
    .ID_VALUE   (32'hA9B0_0001)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .bus (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the completing edge so the
  // next call issues its setup phase back-to-back.
  task automatic apb_xfer(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_waits);
    int waits;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(negedge pclk);
    bus.penable = 1'b1;
    waits = 0;
    while (!bus.pready && waits < 40) begin
      waits++;
      @(negedge pclk);
    end
    if (!bus.pready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: pready never rose within %0d cycles", name, waits);
    end else begin
      check({name, "_waits"}, 32'(waits), 32'(exp_waits));
      check({name, "_rdata"}, bus.prdata, exp_rdata);
      check({name, "_err"}, {31'd0, bus.pslverr}, {31'd0, exp_err});
    end
    @(negedge pclk);
  endtask

  task automatic go_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    // write, addr, wdata, expected prdata, expected pslverr, expected wait cycles
    vecs[0]  = '{1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0, 0};
    vecs[1]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[3]  = '{1'b1, 32'h04, 32'hFFFF_FFF3, 32'h0,         1'b0, 0};
    vecs[4]  = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vecs[5]  = '{1'b0, 32'h04, 32'h0,         32'h0000_0003, 1'b0, 3};
    vecs[6]  = '{1'b1, 32'h00, 32'h1,         32'h0,         1'b1, 3};
    vecs[7]  = '{1'b0, 32'h40, 32'h0,         32'h0,         1'b1, 3};
    vecs[8]  = '{1'b1, 32'h09, 32'h55,        32'h0,         1'b1, 3};
    vecs[9]  = '{1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0, 3};
    vecs[10] = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vecs[11] = '{1'b1, 32'h3C, 32'hCAFE_F00D, 32'h0,         1'b0, 3};
    vecs[12] = '{1'b0, 32'h3C, 32'h0,         32'hCAFE_F00D, 1'b0, 3};
    vecs[13] = '{1'b0, 32'h3E, 32'h0,         32'h0,         1'b1, 3};
    vecs[14] = '{1'b1, 32'h04, 32'h0,         32'h0,         1'b0, 3};
    vecs[15] = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0, 0};

    prst        = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 32'h0;
    bus.pwdata  = 32'h0;
    repeat (3) @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    check("reset_pready", {31'd0, bus.pready}, 32'd0);
    check("reset_pslverr", {31'd0, bus.pslverr}, 32'd0);
    check("reset_prdata", bus.prdata, 32'd0);

    // Access strobe with no setup phase must be ignored.
    bus.psel    = 1'b1;
    bus.penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("nosetup_pready%0d", i), {31'd0, bus.pready}, 32'd0);
    end
    go_idle();

    for (int i = 0; i < 16; i++) begin
      apb_xfer($sformatf("v%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_waits);
    end
    go_idle();
    check("idle_pready", {31'd0, bus.pready}, 32'd0);

    // Abort: WAITCFG=5, drop psel after two wait cycles of a write to reg3.
    apb_xfer("set_wait5", 1'b1, 32'h04, 32'h5, 32'h0, 1'b0, 0);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h0C;
    bus.pwdata  = 32'h1234;
    @(negedge pclk);
    bus.penable = 1'b1;
    check("abort_wait1", {31'd0, bus.pready}, 32'd0);
    @(negedge pclk);
    check("abort_wait2", {31'd0, bus.pready}, 32'd0);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("abort_idle%0d", i), {31'd0, bus.pready}, 32'd0);
    end
    apb_xfer("abort_reg3", 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 5);
    apb_xfer("abort_read_id", 1'b0, 32'h00, 32'h0, 32'hA9B0_0001, 1'b0, 5);

    // Reset during the third wait cycle of a write to reg4.
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h10;
    bus.pwdata  = 32'h77;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    check("rst_pready", {31'd0, bus.pready}, 32'd0);
    check("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
    check("rst_prdata", bus.prdata, 32'd0);
    prst = 1'b1;
    go_idle();
    apb_xfer("rst_waitcfg", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 0);
    apb_xfer("rst_reg4", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0);
    apb_xfer("rst_reg2", 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 0);
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
